// File: rtl/pll_mon_pkg.sv
// Shared types and constants for the PLL lock monitor.
package pll_mon_pkg;

    // One-hot state encoding; any other pattern is treated as illegal.
    typedef enum logic [4:0] {
        S_PLL_RST   = 5'b00001,
        S_WAIT_LOCK = 5'b00010,
        S_SETTLE    = 5'b00100,
        S_RUN       = 5'b01000,
        S_FAIL      = 5'b10000
    } state_e;

    localparam int unsigned LOSS_W       = 8;
    localparam int unsigned RETRY_W      = 3;
    localparam int unsigned LOSS_CNT_MAX = 255;

    // Bits needed for a counter that must reach (max of the three periods) - 1.
    function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                              input int unsigned lock_timeout,
                                              input int unsigned settle_cycles);
        int unsigned m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (settle_cycles > m) m = settle_cycles;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for single-bit asynchronous signals.
// Tie d high to build a reset synchroniser (async assert, sync deassert).
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    // Shift chain, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL supervisor: drives the PLL reset, retries on lock timeout, and releases
// downstream reset only after lock has been stable. Runs on the reference clock.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    output logic               pll_rst,
    output logic               user_rst_n,
    output logic               locked_stable,
    output logic               pll_fail,
    output logic [LOSS_W-1:0]  lock_loss_cnt,
    output logic [RETRY_W-1:0] retry_cnt
);

    // Never narrower than the periods actually require.
    localparam int unsigned CNT_MIN_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam int unsigned CW        = (CNT_W > CNT_MIN_W) ? CNT_W : CNT_MIN_W;

    localparam logic [CW-1:0]      RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]      TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]      SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [LOSS_W-1:0]  LOSS_LIMIT   = LOSS_W'(LOSS_CNT_MAX);

    logic rst_sync_n;
    logic lock_s;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               pll_rst_q, run_q, fail_q;

    // Internal reset: asserts with rst_n, releases on a clock edge.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (1'b1),
        .q     (rst_sync_n)
    );

    // Lock flag comes from another clock domain; the FSM only sees lock_s.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next-state, retry and loss-count decode.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_d = S_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 3'd1;
                    state_d = (retry_d == RETRY_LIMIT) ? S_FAIL : S_PLL_RST;
                end
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    if (loss_q != LOSS_LIMIT) loss_d = loss_q + 8'd1;
                    state_d = S_PLL_RST;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    end

    // State, counters and outputs; outputs decoded from state_d so they
    // line up with the state register.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            run_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= (state_d == S_PLL_RST);
            run_q     <= (state_d == S_RUN);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign user_rst_n    = run_q;
    assign locked_stable = run_q;
    assign pll_fail      = fail_q;
    assign lock_loss_cnt = loss_q;
    assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Event scoreboard bench: stimulus pushes expected output changes (cycle and
// value); the monitor pops one entry each time the DUT outputs change.
module tb_pll_lock_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_rst;
    logic       user_rst_n;
    logic       locked_stable;
    logic       pll_fail;
    logic [7:0] lock_loss_cnt;
    logic [2:0] retry_cnt;

    typedef struct packed {
        logic       pll_rst;
        logic       user_rst_n;
        logic       locked_stable;
        logic       pll_fail;
        logic [7:0] loss;
        logic [2:0] retry;
    } snap_t;

    typedef struct {
        int unsigned cyc;
        snap_t       s;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc   = 0;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;

    pll_lock_monitor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (100),
        .SETTLE_CYCLES (8),
        .MAX_RETRY     (2),
        .CNT_W         (16),
        .SYNC_STAGES   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .pll_rst       (pll_rst),
        .user_rst_n    (user_rst_n),
        .locked_stable (locked_stable),
        .pll_fail      (pll_fail),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t mk(input bit pr, input bit ur, input bit ls, input bit pf,
                                 input logic [7:0] l, input logic [2:0] r);
        snap_t s;
        s.pll_rst = pr; s.user_rst_n = ur; s.locked_stable = ls; s.pll_fail = pf;
        s.loss = l; s.retry = r;
        return s;
    endfunction

    function automatic string str(input snap_t s);
        return $sformatf("cyc pll_rst=%b user_rst_n=%b locked=%b fail=%b loss=%0d retry=%0d",
                         s.pll_rst, s.user_rst_n, s.locked_stable, s.pll_fail, s.loss, s.retry);
    endfunction

    task automatic push(input string n, input int unsigned c, input snap_t s);
        exp_t e;
        e.cyc = c; e.s = s; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every output change must match the next expected event.
    initial begin
        snap_t cur, prev;
        bit    first;
        exp_t  e;
        first = 1'b1;
        prev  = '0;
        wait (mon_en);
        forever begin
            #1;
            cur = {pll_rst, user_rst_n, locked_stable, pll_fail, lock_loss_cnt, retry_cnt};
            if (first || cur !== prev) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %0d %s, wanted no change",
                             cyc, str(cur));
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.s !== cur) begin
                        fails++;
                        $display("FAIL %s: got %0d %s, want %0d %s",
                                 e.name, cyc, str(cur), e.cyc, str(e.s));
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
            @(negedge clk);
        end
    end

    // Stimulus
    initial begin
        int unsigned c0;
        int unsigned c;
        snap_t       rs;
        logic [7:0]  l;
        rs       = mk(1, 0, 0, 0, 8'd0, 3'd0);
        rst_n    = 1'b1;
        pll_lock = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        push("reset_values", cyc, rs);
        mon_en = 1'b1;
        tick(2);

        // Normal bring-up: PLL reset 4 cycles after the 2-flop reset release,
        // lock 20 cycles after release, RUN 2+8+1 cycles after the lock edge.
        rst_n = 1'b1;
        c0 = cyc;
        push("bringup_pll_rst_fall", c0 + 6, mk(0, 0, 0, 0, 8'd0, 3'd0));
        tick(20);
        pll_lock = 1'b1;
        push("bringup_run", c0 + 31, mk(0, 1, 1, 0, 8'd0, 3'd0));
        tick(11);

        // 260 one-cycle lock drops in RUN; each replays reset/wait/settle.
        for (int i = 1; i <= 260; i++) begin
            c = cyc;
            l = (i > 255) ? 8'd255 : 8'(i);
            push($sformatf("loss%0d_user_rst_fall", i), c + 3, mk(1, 0, 0, 0, l, 3'd0));
            push($sformatf("loss%0d_pll_rst_fall", i), c + 7, mk(0, 0, 0, 0, l, 3'd0));
            push($sformatf("loss%0d_run", i), c + 16, mk(0, 1, 1, 0, l, 3'd0));
            pll_lock = 1'b0;
            tick(1);
            pll_lock = 1'b1;
            tick(15);
        end

        // One more drop, then rst_n asserted while in S_SETTLE.
        c = cyc;
        push("loss261_user_rst_fall", c + 3, mk(1, 0, 0, 0, 8'd255, 3'd0));
        push("loss261_pll_rst_fall", c + 7, mk(0, 0, 0, 0, 8'd255, 3'd0));
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(9);
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        push("reset_mid_settle", cyc, rs);
        tick(2);

        // One timeout (retry 1), then settle abort: 5 high, 3 low, high.
        rst_n = 1'b1;
        c0 = cyc;
        push("abort_pll_rst_fall", c0 + 6, mk(0, 0, 0, 0, 8'd0, 3'd0));
        push("abort_retry1", c0 + 106, mk(1, 0, 0, 0, 8'd0, 3'd1));
        push("abort_retry1_pulse_end", c0 + 110, mk(0, 0, 0, 0, 8'd0, 3'd1));
        tick(120);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(3);
        pll_lock = 1'b1;
        push("abort_run", c0 + 139, mk(0, 1, 1, 0, 8'd0, 3'd0));
        tick(20);

        // Lock never arrives: two timeouts then terminal fail for 1000 cycles.
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        push("reset_from_run", cyc, rs);
        tick(2);
        rst_n = 1'b1;
        c0 = cyc;
        push("to_pll_rst_fall", c0 + 6, mk(0, 0, 0, 0, 8'd0, 3'd0));
        push("to_retry1", c0 + 106, mk(1, 0, 0, 0, 8'd0, 3'd1));
        push("to_retry1_pulse_end", c0 + 110, mk(0, 0, 0, 0, 8'd0, 3'd1));
        push("to_fail", c0 + 210, mk(0, 0, 0, 1, 8'd0, 3'd2));
        tick(1215);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL events_outstanding: got %0d pending (next %s), want 0",
                     exp_q.size(), exp_q[0].name);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
